csr_trap_unit: RTL and testbench

- Machine-mode CSR file and trap sequencer for the 5-stage RV32 core.
- Consumes the decoded CSR/MRET/ECALL qualifiers of the instruction in MEM.
- Generates trap_taken, mret_exec and the redirect target that the control unit uses to flush and redirect the pipeline.
- Holds mstatus, mie, mip, mtvec, mepc, mcause and mscratch.

---
 rtl/csr_trap_unit.sv | 196 +++++++++++++++++++
 tb/tb_csr_trap_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap sequencer for the 5-stage RV32 core.
// Holds mstatus, mie, mip, mtvec, mepc, mcause and mscratch, arbitrates
// interrupt / ECALL / MRET / CSR write for the instruction in MEM, and
// produces registered trap/MRET pulses plus the pipeline redirect target.
// Optional feature: define CSR_COUNTERS_EN to add mcycle/minstret (64-bit).
module csr_trap_unit #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0100,
  parameter logic [31:0] MEPC_RESET  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_pipl,
  input  logic        instr_valid_mem,
  input  logic [31:0] pc_mem,
  input  logic        is_csr_instr_mem,
  input  logic        csr_write_mem,
  input  logic [2:0]  fun3_mem,
  input  logic [11:0] csr_addr_mem,
  input  logic [31:0] csr_wdata_mem,
  input  logic        is_mret_mem,
  input  logic        is_ecall_mem,
  input  logic        ext_irq,
  input  logic        timer_irq,
  output logic [31:0] csr_rdata,
  output logic        trap_taken,
  output logic        mret_exec,
  output logic [31:0] redirect_pc
);

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MIP      = 12'h344;

  state_t      r_state, w_state_next;
  logic        r_mstatus_mie, r_mstatus_mpie;
  logic [31:0] r_mie, r_mtvec, r_mepc, r_mcause, r_mscratch;
  logic        r_trap_taken, r_mret_exec;
  logic [31:0] r_redirect_pc;

  logic [31:0] w_mstatus, w_mip, w_old, w_new;
  logic        w_commit, w_irq_pending, w_take_irq, w_take_ecall, w_take_mret;
  logic        w_csr_op, w_csr_wr;

  // MPP is hardwired to M-mode; only MIE and MPIE are stored.
  assign w_mstatus = {19'd0, 2'b11, 3'd0, r_mstatus_mpie, 3'd0, r_mstatus_mie, 3'd0};
  // mip mirrors the live interrupt levels and has no storage.
  assign w_mip     = {20'd0, ext_irq, 3'd0, timer_irq, 7'd0};

  assign w_commit      = instr_valid_mem & ~stall_pipl & (r_state == ST_RUN);
  assign w_irq_pending = r_mstatus_mie & (|(r_mie & w_mip));
  assign w_take_irq    = w_commit & w_irq_pending;
  assign w_take_ecall  = w_commit & ~w_irq_pending & is_ecall_mem;
  assign w_take_mret   = w_commit & ~w_irq_pending & ~is_ecall_mem & is_mret_mem;
  assign w_csr_wr      = w_commit & ~w_irq_pending & ~is_ecall_mem & ~is_mret_mem &
                         is_csr_instr_mem & csr_write_mem & w_csr_op;

`ifdef CSR_COUNTERS_EN
  logic [63:0] r_mcycle, r_minstret;
`endif

  // Read mux: pre-update value of the addressed CSR, 0 for unimplemented.
  always_comb begin
    // NOTE: default first so every path assigns w_old; a missing default infers a latch.
    w_old = 32'd0;
    case (csr_addr_mem)
      A_MSTATUS:  w_old = w_mstatus;
      A_MIE:      w_old = r_mie;
      A_MTVEC:    w_old = r_mtvec;
      A_MSCRATCH: w_old = r_mscratch;
      A_MEPC:     w_old = r_mepc;
      A_MCAUSE:   w_old = r_mcause;
      A_MIP:      w_old = w_mip;
`ifdef CSR_COUNTERS_EN
      12'hB00:    w_old = r_mcycle[31:0];
      12'hB80:    w_old = r_mcycle[63:32];
      12'hB02:    w_old = r_minstret[31:0];
      12'hB82:    w_old = r_minstret[63:32];
`endif
      default:    w_old = 32'd0;
    endcase
  end

  assign csr_rdata = w_old;

  // New value for CSRRW / CSRRS / CSRRC; other encodings perform no write.
  always_comb begin
    w_new    = w_old;
    w_csr_op = 1'b1;
    case (fun3_mem)
      3'b001, 3'b101: w_new = csr_wdata_mem;
      3'b010, 3'b110: w_new = w_old | csr_wdata_mem;
      3'b011, 3'b111: w_new = w_old & ~csr_wdata_mem;
      default:        w_csr_op = 1'b0;
    endcase
  end

  // Next-state: any trap or MRET spends one cycle in FLUSH.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN:   if (w_take_irq | w_take_ecall | w_take_mret) w_state_next = ST_FLUSH;
      ST_FLUSH: w_state_next = ST_RUN;
      default:  w_state_next = ST_RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_state_next;
  end

  // Architectural CSR updates and trap/MRET pulses, in priority order.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking throughout so every update sees this cycle's old values.
    if (reset) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mie          <= 32'd0;
      r_mtvec        <= MTVEC_RESET;
      r_mepc         <= MEPC_RESET;
      r_mcause       <= 32'd0;
      r_mscratch     <= 32'd0;
      r_trap_taken   <= 1'b0;
      r_mret_exec    <= 1'b0;
      r_redirect_pc  <= 32'd0;
    end else begin
      r_trap_taken <= 1'b0;
      r_mret_exec  <= 1'b0;
      if (w_take_irq || w_take_ecall) begin
        r_mepc         <= pc_mem;
        r_mcause       <= w_take_ecall ? 32'd11 :
                          (ext_irq & r_mie[11]) ? {1'b1, 31'd11} : {1'b1, 31'd7};
        r_mstatus_mpie <= r_mstatus_mie;
        r_mstatus_mie  <= 1'b0;
        r_redirect_pc  <= r_mtvec;
        r_trap_taken   <= 1'b1;
      end else if (w_take_mret) begin
        r_mstatus_mie  <= r_mstatus_mpie;
        r_mstatus_mpie <= 1'b1;
        r_redirect_pc  <= r_mepc;
        r_mret_exec    <= 1'b1;
      end else if (w_csr_wr) begin
        case (csr_addr_mem)
          A_MSTATUS: begin
            r_mstatus_mie  <= w_new[3];
            r_mstatus_mpie <= w_new[7];
          end
          A_MIE:      r_mie      <= w_new & 32'h0000_0880;
          A_MTVEC:    r_mtvec    <= {w_new[31:2], 2'b00};
          A_MSCRATCH: r_mscratch <= w_new;
          A_MEPC:     r_mepc     <= {w_new[31:2], 2'b00};
          A_MCAUSE:   r_mcause   <= w_new;
          default:    ;
        endcase
      end
    end
  end

`ifdef CSR_COUNTERS_EN
  logic [63:0] w_cyc_inc, w_ret_inc;
  logic        w_retire;

  assign w_retire  = w_commit & ~w_take_irq & ~w_take_ecall;
  assign w_cyc_inc = r_mcycle + 64'd1;
  assign w_ret_inc = r_minstret + {63'd0, w_retire};

  // Counters; a CSR write to a half replaces that half's increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mcycle   <= 64'd0;
      r_minstret <= 64'd0;
    end else begin
      r_mcycle[31:0]    <= (w_csr_wr && csr_addr_mem == 12'hB00) ? w_new : w_cyc_inc[31:0];
      r_mcycle[63:32]   <= (w_csr_wr && csr_addr_mem == 12'hB80) ? w_new :
                           (w_csr_wr && csr_addr_mem == 12'hB00) ? r_mcycle[63:32] :
                           w_cyc_inc[63:32];
      r_minstret[31:0]  <= (w_csr_wr && csr_addr_mem == 12'hB02) ? w_new : w_ret_inc[31:0];
      r_minstret[63:32] <= (w_csr_wr && csr_addr_mem == 12'hB82) ? w_new :
                           (w_csr_wr && csr_addr_mem == 12'hB02) ? r_minstret[63:32] :
                           w_ret_inc[63:32];
    end
  end
`endif

  assign trap_taken  = r_trap_taken;
  assign mret_exec   = r_mret_exec;
  assign redirect_pc = r_redirect_pc;

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed self-checking bench for csr_trap_unit.
// Inputs change 1 ns after a rising edge; registered outputs are sampled
// at the same point, combinational csr_rdata 1 ns after inputs settle.
module tb_csr_trap_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_pipl;
  logic        instr_valid_mem;
  logic [31:0] pc_mem;
  logic        is_csr_instr_mem;
  logic        csr_write_mem;
  logic [2:0]  fun3_mem;
  logic [11:0] csr_addr_mem;
  logic [31:0] csr_wdata_mem;
  logic        is_mret_mem;
  logic        is_ecall_mem;
  logic        ext_irq;
  logic        timer_irq;
  logic [31:0] csr_rdata;
  logic        trap_taken;
  logic        mret_exec;
  logic [31:0] redirect_pc;

  int n_tests = 0;
  int n_fail  = 0;

  csr_trap_unit dut (
    .clk              (clk),
    .reset            (reset),
    .stall_pipl       (stall_pipl),
    .instr_valid_mem  (instr_valid_mem),
    .pc_mem           (pc_mem),
    .is_csr_instr_mem (is_csr_instr_mem),
    .csr_write_mem    (csr_write_mem),
    .fun3_mem         (fun3_mem),
    .csr_addr_mem     (csr_addr_mem),
    .csr_wdata_mem    (csr_wdata_mem),
    .is_mret_mem      (is_mret_mem),
    .is_ecall_mem     (is_ecall_mem),
    .ext_irq          (ext_irq),
    .timer_irq        (timer_irq),
    .csr_rdata        (csr_rdata),
    .trap_taken       (trap_taken),
    .mret_exec        (mret_exec),
    .redirect_pc      (redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_instr();
    instr_valid_mem  = 1'b0;
    pc_mem           = 32'd0;
    is_csr_instr_mem = 1'b0;
    csr_write_mem    = 1'b0;
    fun3_mem         = 3'b000;
    csr_addr_mem     = 12'd0;
    csr_wdata_mem    = 32'd0;
    is_mret_mem      = 1'b0;
    is_ecall_mem     = 1'b0;
  endtask

  // Combinational read of a CSR with no instruction committing.
  task automatic read_chk(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    clear_instr();
    csr_addr_mem = addr;
    #1;
    check(tag, csr_rdata, exp);
  endtask

  // Present a committing CSR instruction, check the old value, clock it in.
  task automatic csr_op(input string tag, input logic [2:0] f3, input logic [11:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_old);
    clear_instr();
    instr_valid_mem  = 1'b1;
    is_csr_instr_mem = 1'b1;
    csr_write_mem    = 1'b1;
    fun3_mem         = f3;
    csr_addr_mem     = addr;
    csr_wdata_mem    = wdata;
    #1;
    check(tag, csr_rdata, exp_old);
    step();
    clear_instr();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; stall_pipl = 1'b0; ext_irq = 1'b0; timer_irq = 1'b0;
    clear_instr();
    step(); step();
    reset = 1'b0;

    // Reset state (mstatus reads MPP=11 -> 0x1800).
    check("rst_trap", trap_taken, 32'd0);
    check("rst_mret", mret_exec, 32'd0);
    check("rst_redir", redirect_pc, 32'd0);
    read_chk("rst_mtvec", 12'h305, 32'h100);
    read_chk("rst_mstatus", 12'h300, 32'h1800);
    read_chk("rst_mie", 12'h304, 32'h0);
    read_chk("rst_mepc", 12'h341, 32'h0);
    read_chk("rst_mcause", 12'h342, 32'h0);

    // CSR read-modify-write ops on mscratch.
    csr_op("rw_old", 3'b001, 12'h340, 32'hDEADBEEF, 32'h0);
    csr_op("rs_old", 3'b010, 12'h340, 32'h1, 32'hDEADBEEF);
    read_chk("rs_val", 12'h340, 32'hDEADBEEF);
    csr_op("rc_old", 3'b111, 12'h340, 32'hF, 32'hDEADBEEF);
    read_chk("rc_val", 12'h340, 32'hDEADBEE0);

    // Write masks and unimplemented / read-only addresses.
    csr_op("mtvec_w", 3'b101, 12'h305, 32'h203, 32'h100);
    read_chk("mtvec_mask", 12'h305, 32'h200);
    csr_op("mie_w", 3'b001, 12'h304, 32'hFFFF_FFFF, 32'h0);
    read_chk("mie_mask", 12'h304, 32'h880);
    csr_op("mie_w2", 3'b001, 12'h304, 32'h800, 32'h880);
    csr_op("mip_w", 3'b001, 12'h344, 32'hFFFF_FFFF, 32'h0);
    read_chk("mip_ro", 12'h344, 32'h0);
    csr_op("unimp_w", 3'b001, 12'h123, 32'h1234_5678, 32'h0);
    read_chk("unimp_rd", 12'h123, 32'h0);
    csr_op("mstatus_w", 3'b010, 12'h300, 32'hFFFF_FF08, 32'h1800);
    read_chk("mstatus_mask", 12'h300, 32'h1808);

    // Stalled and bubble CSR writes are dropped.
    csr_addr_mem = 12'h340;
    instr_valid_mem = 1'b1; is_csr_instr_mem = 1'b1; csr_write_mem = 1'b1;
    fun3_mem = 3'b001; csr_addr_mem = 12'h340; csr_wdata_mem = 32'h1111_1111;
    stall_pipl = 1'b1;
    step();
    stall_pipl = 1'b0; instr_valid_mem = 1'b0;
    step();
    read_chk("stall_bubble_wr", 12'h340, 32'hDEADBEE0);

    // External interrupt with a CSR write in MEM: write is suppressed.
    clear_instr();
    ext_irq = 1'b1;
    instr_valid_mem = 1'b1; pc_mem = 32'h40;
    is_csr_instr_mem = 1'b1; csr_write_mem = 1'b1; fun3_mem = 3'b001;
    csr_addr_mem = 12'h340; csr_wdata_mem = 32'hAAAA;
    step();
    clear_instr(); ext_irq = 1'b0;
    check("irq_trap", trap_taken, 32'd1);
    check("irq_redir", redirect_pc, 32'h200);
    check("irq_nomret", mret_exec, 32'd0);
    step();
    check("irq_pulse1", trap_taken, 32'd0);
    read_chk("irq_mepc", 12'h341, 32'h40);
    read_chk("irq_mcause", 12'h342, 32'h8000_000B);
    read_chk("irq_mstatus", 12'h300, 32'h1880);
    read_chk("irq_mscratch", 12'h340, 32'hDEADBEE0);

    // MRET returns to mepc and restores MIE.
    instr_valid_mem = 1'b1; is_mret_mem = 1'b1; pc_mem = 32'h200;
    step();
    clear_instr();
    check("mret_pulse", mret_exec, 32'd1);
    check("mret_redir", redirect_pc, 32'h40);
    check("mret_notrap", trap_taken, 32'd0);
    step();
    check("mret_pulse1", mret_exec, 32'd0);
    read_chk("mret_mstatus", 12'h300, 32'h1888);

    // Both interrupts pending under a 3-cycle stall; ext wins on release.
    csr_op("mie_both", 3'b001, 12'h304, 32'h880, 32'h800);
    ext_irq = 1'b1; timer_irq = 1'b1;
    read_chk("mip_live", 12'h344, 32'h880);
    instr_valid_mem = 1'b1; pc_mem = 32'h60; stall_pipl = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("stall_notrap%0d", i), trap_taken, 32'd0);
    end
    stall_pipl = 1'b0;
    step();
    clear_instr(); ext_irq = 1'b0; timer_irq = 1'b0;
    check("stall_trap", trap_taken, 32'd1);
    step();
    read_chk("stall_mcause", 12'h342, 32'h8000_000B);
    read_chk("stall_mepc", 12'h341, 32'h60);

    // ECALL beats a CSR write in the same slot; FLUSH ignores the next one.
    instr_valid_mem = 1'b1; is_ecall_mem = 1'b1; pc_mem = 32'h80;
    is_csr_instr_mem = 1'b1; csr_write_mem = 1'b1; fun3_mem = 3'b001;
    csr_addr_mem = 12'h340; csr_wdata_mem = 32'h1234_5678;
    step();
    check("ecall_trap", trap_taken, 32'd1);
    check("ecall_redir", redirect_pc, 32'h200);
    pc_mem = 32'hC0;
    step();
    clear_instr();
    check("flush_ignored", trap_taken, 32'd0);
    step();
    check("flush_ignored2", trap_taken, 32'd0);
    read_chk("ecall_mcause", 12'h342, 32'd11);
    read_chk("ecall_mepc", 12'h341, 32'h80);
    read_chk("ecall_mscratch", 12'h340, 32'hDEADBEE0);
    read_chk("ecall_mstatus", 12'h300, 32'h1800);

    // Pending interrupt with a bubble in MEM is not taken.
    csr_op("mie_set", 3'b010, 12'h300, 32'h8, 32'h1800);
    ext_irq = 1'b1;
    step();
    check("bubble_notrap", trap_taken, 32'd0);
    ext_irq = 1'b0;

    // Reset while in FLUSH clears pulses and returns to RUN.
    instr_valid_mem = 1'b1; is_ecall_mem = 1'b1; pc_mem = 32'h90;
    step();
    clear_instr();
    check("rf_trap", trap_taken, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rf_pulse", trap_taken, 32'd0);
    check("rf_redir", redirect_pc, 32'd0);
    read_chk("rf_mtvec", 12'h305, 32'h100);
    csr_op("rf_run", 3'b001, 12'h340, 32'h55, 32'h0);
    read_chk("rf_run_val", 12'h340, 32'h55);

`ifdef CSR_COUNTERS_EN
    csr_op("mcycleh_w", 3'b001, 12'hB80, 32'h5, 32'h0);
    read_chk("mcycleh_val", 12'hB80, 32'h5);
`else
    csr_op("mcycle_w", 3'b001, 12'hB00, 32'h77, 32'h0);
    read_chk("mcycle_absent", 12'hB00, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
